bus_master_init_seq: RTL and testbench
======================================

BUS_MASTER_INIT_SEQ -- requirements
Module: bus_master_init_seq

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning number of init writes issued (1..1024).
REQ-002 SHALL have parameter ADDR_BASE, default 0, meaning address of the first write.
REQ-003 SHALL have parameter ADDR_STRIDE, default 1, meaning address increment per word.
REQ-004 SHALL have parameter DATA_SEED, default 0, meaning data of the first write.
REQ-005 SHALL have parameter DATA_INCR, default 1, meaning data increment per word.
REQ-006 SHALL have parameter START_DELAY, default 4, meaning idle cycles after reset release before the first command.
REQ-007 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-008 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-009 SHALL have port bus  Bus_if.master  -  bus master port (MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n out; SCmdAccept, SResp, SData in).
REQ-010 SHALL have port busy  out  1  high while the sequence runs.
REQ-011 SHALL have port done  out  1  sticky; high once the sequence has ended.
REQ-012 SHALL have port error  out  1  sticky; high after any Bus::ERR/Bus::FAIL response or readback mismatch.
REQ-013 SHALL have port count  out  $clog2(NUM_WORDS+1)  number of words completed.

Function
REQ-014 SHALL use states WAIT, CMD, RESP and DONE, plus RD_CMD and RD_RESP when REQ-027 applies.
REQ-015 In WAIT, SHALL count START_DELAY cycles and then enter CMD; START_DELAY=0 SHALL enter CMD on the first cycle after reset release.
REQ-016 In CMD, SHALL drive MCmd=Bus::WR, MAddr=ADDR_BASE+i*ADDR_STRIDE, MData=DATA_SEED+i*DATA_INCR and MByteEn all ones; i is the word index.
REQ-017 Address and data SHALL be computed by accumulation, not multiplication, and SHALL wrap modulo the bus width.
REQ-018 SHALL hold all command fields stable until a cycle with SCmdAccept=1; that cycle completes the command and the next state is RESP.
REQ-019 In RESP, SHALL drive MCmd=Bus::IDLE and MRespAccept=1, and SHALL wait for SResp other than Bus::NULL.
REQ-020 A response arriving in the same cycle as the accept SHALL be ignored; responses are sampled only in RESP.
REQ-021 On Bus::DVA, SHALL increment count and then advance i, or enter DONE after the last word.
REQ-022 On Bus::ERR or Bus::FAIL, SHALL set error, increment count and continue the sequence; the sequence does not abort.
REQ-023 In DONE, SHALL behave as a bus terminator: MCmd=Bus::IDLE, MAddr/MData/MByteEn='0, MRespAccept=0, done=1 and busy=0, held indefinitely.
REQ-024 MReset_n SHALL equal the synchronised inverse of reset: 0 while reset_n=0, and 1 from the second clk edge after reset_n release.
REQ-025 Outside CMD/RD_CMD, MCmd SHALL be Bus::IDLE; MAddr, MData and MByteEn SHALL be '0 when idle.

Reset
REQ-026 While reset_n=0: state=WAIT, i=0, count=0, busy=1, done=0, error=0, MCmd=Bus::IDLE, MRespAccept=0, all data outputs '0; reset mid-sequence SHALL abandon the outstanding command and restart from word 0.

Configuration
REQ-027 With BUS_MASTER_INIT_SEQ_READBACK_EN defined, after each DVA write response the block SHALL issue Bus::RD to the same address (RD_CMD), await the response (RD_RESP), and set error if SData differs from the written data or SResp is not DVA; count increments only after the read.
REQ-028 Without BUS_MASTER_INIT_SEQ_READBACK_EN, no read commands SHALL be issued and SData SHALL be ignored.

Structure
REQ-029 The state enum and the response-is-error helper SHALL live in package Bus_init_pkg; Bus::IDLE/WR/RD/NULL/DVA/ERR/FAIL SHALL come from package Bus.
REQ-030 The start-delay and MReset_n synchroniser SHALL be sub-module Bus_reset_sequencer.

Verification
REQ-031 Defaults with an always-accepting slave responding DVA one cycle later -> writes to 0..15 with data 0..15; done=1, count=16, error=0.
REQ-032 SCmdAccept held low for 5 cycles on word 3 -> MAddr=3 and MData=3 stable for all 6 cycles; exactly one write to address 3.
REQ-033 Slave returns Bus::ERR on word 7 -> error=1, sequence completes, count=16.
REQ-034 reset_n pulsed low during RESP of word 9 -> outputs at reset values; restart after START_DELAY with MAddr=0.
REQ-035 With BUS_MASTER_INIT_SEQ_READBACK_EN and a memory model corrupting address 5 -> 16 writes and 16 reads issued, error=1.
REQ-036 NUM_WORDS=1, ADDR_STRIDE=4, START_DELAY=0 -> single write to ADDR_BASE; done within 3 cycles of an immediate accept and response.

Source files
------------

// File: rtl/Bus.sv
// Bus protocol definitions shared by masters and slaves.
// Provides bus widths, command codes and response codes.
package Bus;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2
    } cmd_e;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        FAIL = 2'd2,
        ERR  = 2'd3
    } resp_e;

endpackage

// File: rtl/Bus_init_pkg.sv
// Init-sequencer types: FSM state encoding and response helper.
// Read-back states exist only with BUS_MASTER_INIT_SEQ_READBACK_EN.
package Bus_init_pkg;

    typedef enum logic [2:0] {
        WAIT,
        CMD,
        RESP,
`ifdef BUS_MASTER_INIT_SEQ_READBACK_EN
        RD_CMD,
        RD_RESP,
`endif
        DONE
    } state_e;

    function automatic logic resp_is_err(input Bus::resp_e r);
        return (r == Bus::ERR) || (r == Bus::FAIL);
    endfunction

endpackage

// File: rtl/Bus_if.sv
// Request/response bus between a master and a slave.
// Master drives M* signals, slave drives S* signals.
interface Bus_if;

    Bus::cmd_e                 MCmd;
    logic [Bus::ADDR_W-1:0]    MAddr;
    logic [Bus::DATA_W-1:0]    MData;
    logic [Bus::BE_W-1:0]      MByteEn;
    logic                      MRespAccept;
    logic                      MReset_n;
    logic                      SCmdAccept;
    Bus::resp_e                SResp;
    logic [Bus::DATA_W-1:0]    SData;

    modport master (
        output MCmd,
        output MAddr,
        output MData,
        output MByteEn,
        output MRespAccept,
        output MReset_n,
        input  SCmdAccept,
        input  SResp,
        input  SData
    );

    modport slave (
        input  MCmd,
        input  MAddr,
        input  MData,
        input  MByteEn,
        input  MRespAccept,
        input  MReset_n,
        output SCmdAccept,
        output SResp,
        output SData
    );

endinterface

// File: rtl/Bus_reset_sequencer.sv
// Start-delay counter and bus reset synchroniser.
// Ports: clk, reset_n (async low) in; start_ok, mreset_n out.
module Bus_reset_sequencer #(
    parameter int START_DELAY = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic start_ok,
    output logic mreset_n
);

    localparam int DW = (START_DELAY < 1) ? 1 :
                        $clog2(START_DELAY + 1);
    localparam logic [DW-1:0] DLY = DW'(START_DELAY);

    logic [DW-1:0] dly_q;
    logic [1:0]    sync_q;

    // Counter saturates at DLY; start_ok is already high in the
    // partial cycle after release when START_DELAY is zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_q  <= '0;
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
            if (dly_q != DLY) begin
                dly_q <= dly_q + 1'b1;
            end
        end
    end

    assign start_ok = (dly_q == DLY);
    assign mreset_n = sync_q[1];

endmodule

// File: rtl/bus_master_init_seq.sv
// Bus master issuing NUM_WORDS init writes after reset.
// Ports: clk, reset_n in; bus (Bus_if.master);
//   busy, done, error, count out.
// Option: BUS_MASTER_INIT_SEQ_READBACK_EN adds a read-back
//   check of every successfully written word.
module bus_master_init_seq
    import Bus_init_pkg::*;
#(
    parameter int NUM_WORDS   = 16,
    parameter int ADDR_BASE   = 0,
    parameter int ADDR_STRIDE = 1,
    parameter int DATA_SEED   = 0,
    parameter int DATA_INCR   = 1,
    parameter int START_DELAY = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    Bus_if.master                          bus,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(NUM_WORDS+1)-1:0] count
);

    localparam int AW = Bus::ADDR_W;
    localparam int DW = Bus::DATA_W;
    localparam int IW = (NUM_WORDS < 2) ? 1 :
                        $clog2(NUM_WORDS);
    localparam int CW = $clog2(NUM_WORDS + 1);

    localparam logic [AW-1:0] A0   = AW'(ADDR_BASE);
    localparam logic [AW-1:0] AS   = AW'(ADDR_STRIDE);
    localparam logic [DW-1:0] D0   = DW'(DATA_SEED);
    localparam logic [DW-1:0] DI   = DW'(DATA_INCR);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [IW-1:0]   idx_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            start_ok;
    logic            mreset_n;
    logic            adv;
    logic            cnt_inc;
    logic            err_set;

    Bus_reset_sequencer #(
        .START_DELAY(START_DELAY)
    ) u_rst_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_ok (start_ok),
        .mreset_n (mreset_n)
    );

    assign bus.MReset_n = mreset_n;

    always_comb begin
        state_d         = state_q;
        adv             = 1'b0;
        cnt_inc         = 1'b0;
        err_set         = 1'b0;
        bus.MCmd        = Bus::IDLE;
        bus.MAddr       = '0;
        bus.MData       = '0;
        bus.MByteEn     = '0;
        bus.MRespAccept = 1'b0;

        unique case (state_q)
            WAIT: begin
                if (start_ok) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                bus.MCmd    = Bus::WR;
                bus.MAddr   = addr_q;
                bus.MData   = data_q;
                bus.MByteEn = '1;
                if (bus.SCmdAccept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.MRespAccept = 1'b1;
                if (bus.SResp != Bus::NULL) begin
`ifdef BUS_MASTER_INIT_SEQ_READBACK_EN
                    if (bus.SResp == Bus::DVA) begin
                        state_d = RD_CMD;
                    end else begin
                        err_set = resp_is_err(bus.SResp);
                        cnt_inc = 1'b1;
                        adv     = 1'b1;
                    end
`else
                    err_set = resp_is_err(bus.SResp);
                    cnt_inc = 1'b1;
                    adv     = 1'b1;
`endif
                end
            end
`ifdef BUS_MASTER_INIT_SEQ_READBACK_EN
            RD_CMD: begin
                bus.MCmd    = Bus::RD;
                bus.MAddr   = addr_q;
                bus.MByteEn = '1;
                if (bus.SCmdAccept) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                bus.MRespAccept = 1'b1;
                if (bus.SResp != Bus::NULL) begin
                    err_set = (bus.SResp != Bus::DVA) ||
                              (bus.SData != data_q);
                    cnt_inc = 1'b1;
                    adv     = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT;
            end
        endcase

        if (adv) begin
            state_d = (idx_q == LAST) ? DONE : CMD;
        end
    end

    // Address and data advance by accumulation and wrap at
    // the bus width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT;
            idx_q   <= '0;
            addr_q  <= A0;
            data_q  <= D0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (adv && (idx_q != LAST)) begin
                idx_q  <= idx_q + 1'b1;
                addr_q <= addr_q + AS;
                data_q <= data_q + DI;
            end
        end
    end

    assign busy  = (state_q != DONE);
    assign done  = (state_q == DONE);
    assign error = err_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_bus_master_init_seq.sv
// Scoreboard bench for bus_master_init_seq with a random slave.
// A second instance exercises the single-word, no-delay build.
module tb_bus_master_init_seq;

    localparam int N     = 16;
    localparam int SD    = 4;
    localparam int ABASE = 0;
    localparam int ASTR  = 1;
    localparam int DSEED = 0;
    localparam int DINC  = 1;

    typedef struct {
        Bus::cmd_e   cmd;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_data;
        int          cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy, done, error;
    logic [4:0] count;

    logic       reset2_n = 1'b0;
    logic       busy2, done2, error2;
    logic [0:0] count2;

    Bus_if bus ();
    Bus_if bus2 ();

    always #5 clk = ~clk;

    bus_master_init_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .count   (count)
    );

    bus_master_init_seq #(
        .NUM_WORDS   (1),
        .ADDR_BASE   (32'h40),
        .ADDR_STRIDE (4),
        .DATA_SEED   (32'h1234),
        .DATA_INCR   (1),
        .START_DELAY (0)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset2_n),
        .bus     (bus2),
        .busy    (busy2),
        .done    (done2),
        .error   (error2),
        .count   (count2)
    );

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          err_exp = 0;
    bit          hold_v = 0;
    Bus::cmd_e   s_cmd;
    logic [31:0] s_addr;
    logic [31:0] s_data;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output bit ok);
        int t = 0;
        while (bus.MCmd == Bus::IDLE && t < 100) begin
            step();
            t++;
        end
        ok = (bus.MCmd != Bus::IDLE);
        chk("cmd_seen", {63'd0, ok}, 64'd1);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_q.delete();
        hold_v = 0;
        err_exp = 0;
        bus.SCmdAccept = 1'b0;
        bus.SResp = Bus::NULL;
        bus.SData = '0;
        step();
        step();
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", count, 0);
        chk("rst_mcmd", bus.MCmd, Bus::IDLE);
        chk("rst_raccept", bus.MRespAccept, 0);
        chk("rst_maddr", bus.MAddr, 0);
        chk("rst_mdata", bus.MData, 0);
        chk("rst_mbe", bus.MByteEn, 0);
        chk("rst_mreset", bus.MReset_n, 0);
    endtask

    task automatic release_start();
        int k = 0;
        reset_n = 1'b1;
        do begin
            step();
            k++;
            if (k == 1) chk("mreset_e1", bus.MReset_n, 0);
            if (k == 2) chk("mreset_e2", bus.MReset_n, 1);
        end while (bus.MCmd == Bus::IDLE && k < 50);
        chk("start_delay", k, SD + 1);
        chk("restart_addr", bus.MAddr, ABASE);
    endtask

    task automatic do_word(input int i, input int acc, input int rsp,
                           input Bus::resp_e r, input bit spur,
                           input bit abort, output bit ok);
        exp_t e;
        e.cmd = Bus::WR;
        e.addr = 32'(ABASE + i * ASTR);
        e.data = 32'(DSEED + i * DINC);
        e.chk_data = 1;
        e.cnt = i;
        exp_q.push_back(e);
        wait_cmd(ok);
        if (!ok) return;
        bus.SCmdAccept = 1'b0;
        repeat (acc) step();
        bus.SCmdAccept = 1'b1;
        if (spur) bus.SResp = Bus::ERR;
        step();
        bus.SCmdAccept = 1'b0;
        bus.SResp = Bus::NULL;
        if (abort) return;
        repeat (rsp) step();
        bus.SResp = r;
        step();
        bus.SResp = Bus::NULL;
        if (r != Bus::DVA) err_exp = 1;
`ifdef BUS_MASTER_INIT_SEQ_READBACK_EN
        if (r == Bus::DVA) begin
            e.cmd = Bus::RD;
            e.chk_data = 0;
            exp_q.push_back(e);
            wait_cmd(ok);
            if (!ok) return;
            repeat ($urandom_range(0, 2)) step();
            bus.SCmdAccept = 1'b1;
            step();
            bus.SCmdAccept = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            bus.SResp = Bus::DVA;
            bus.SData = e.data;
            if (e.addr == 32'd5) begin
                bus.SData = e.data ^ 32'h0000_00a5;
                err_exp = 1;
            end
            step();
            bus.SResp = Bus::NULL;
            bus.SData = '0;
        end
`endif
    endtask

    task automatic run(input int mode, input int stop_at);
        bit ok;
        int acc, rsp;
        bit spur;
        Bus::resp_e r;
        for (int i = 0; i < N; i++) begin
            acc = (mode == 0) ? ((i == 3) ? 5 : 0) :
                  int'($urandom_range(0, 3));
            rsp = (mode == 0) ? 0 : int'($urandom_range(0, 3));
            r = Bus::DVA;
            if (mode == 1 && i == 7) r = Bus::ERR;
            if (mode == 3 && $urandom_range(0, 5) == 0) r = Bus::FAIL;
            spur = (mode != 0) && ($urandom_range(0, 2) == 0);
            do_word(i, acc, rsp, r, spur, i == stop_at, ok);
            if (!ok || i == stop_at) break;
        end
    endtask

    task automatic end_check();
        step();
        step();
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_count", count, N);
        chk("end_error", error, err_exp);
        chk("end_q_empty", exp_q.size(), 0);
        chk("end_mcmd", bus.MCmd, Bus::IDLE);
        chk("end_raccept", bus.MRespAccept, 0);
        chk("end_maddr", bus.MAddr, 0);
        chk("end_mdata", bus.MData, 0);
        chk("end_mbe", bus.MByteEn, 0);
    endtask

    // Monitor: stability while stalled, scoreboard pop on accept.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    chk("hold_cmd", bus.MCmd, s_cmd);
                    chk("hold_addr", bus.MAddr, s_addr);
                    chk("hold_data", bus.MData, s_data);
                end
                if (bus.MCmd != Bus::IDLE && bus.SCmdAccept) begin
                    hold_v = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_cmd: got cmd %0d addr 0x%0h want none",
                                 bus.MCmd, bus.MAddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd", bus.MCmd, e.cmd);
                        chk("addr", bus.MAddr, e.addr);
                        chk("count_at_cmd", count, e.cnt);
                        if (e.chk_data) begin
                            chk("data", bus.MData, e.data);
                            chk("byteen", bus.MByteEn, 4'hf);
                        end
                    end
                end else if (bus.MCmd != Bus::IDLE) begin
                    hold_v = 1;
                    s_cmd = bus.MCmd;
                    s_addr = bus.MAddr;
                    s_data = bus.MData;
                end else begin
                    hold_v = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.SCmdAccept = 1'b0;
        bus.SResp = Bus::NULL;
        bus.SData = '0;
        bus2.SCmdAccept = 1'b0;
        bus2.SResp = Bus::NULL;
        bus2.SData = '0;

        apply_reset();
        release_start();
        run(0, -1);
        end_check();

        apply_reset();
        release_start();
        run(1, -1);
        end_check();

        apply_reset();
        release_start();
        run(2, 9);
        apply_reset();
        release_start();
        run(2, -1);
        end_check();

        apply_reset();
        release_start();
        run(3, -1);
        end_check();

        bus2.SCmdAccept = 1'b1;
        step();
        chk("d2_rst_busy", busy2, 1);
        chk("d2_rst_mcmd", bus2.MCmd, Bus::IDLE);
        reset2_n = 1'b1;
        step();
        chk("d2_cmd", bus2.MCmd, Bus::WR);
        chk("d2_addr", bus2.MAddr, 32'h40);
        chk("d2_data", bus2.MData, 32'h1234);
        step();
        bus2.SCmdAccept = 1'b0;
        chk("d2_resp_mcmd", bus2.MCmd, Bus::IDLE);
        chk("d2_raccept", bus2.MRespAccept, 1);
        bus2.SResp = Bus::DVA;
        step();
        bus2.SResp = Bus::NULL;
        chk("d2_done", done2, 1);
        chk("d2_busy", busy2, 0);
        chk("d2_count", count2, 1);
        chk("d2_error", error2, 0);
        step();
        step();
        chk("d2_idle_after", bus2.MCmd, Bus::IDLE);
        chk("d2_done_sticky", done2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
